// File: rtl/hex_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// hex_scroll_ctrl
//   Scrolls a DEPTH-entry character buffer across six 7-segment displays.
//   HEX5 shows buf[Pos] and HEX0 shows buf[(Pos+5) mod L], where L is Len
//   clamped to 1..DEPTH. The window advances one position on each Tick while
//   the controller is scrolling and Run is high.
//
//   Ports:
//     Clock            system clock, rising edge
//     Reset_n          asynchronous active-low reset (also restores buffer)
//     Tick             one-cycle advance strobe from the prescaler
//     Run              level: 1 = scroll, 0 = hold
//     Len   [AW:0]     active message length; 0 acts as 1, >DEPTH as DEPTH
//     Wr_en/Wr_addr/Wr_char   buffer write port, usable in any state
//     HEX5..HEX0 [6:0] active-low segments {g,f,e,d,c,b,a}, registered
//     Pos   [AW-1:0]   buffer index shown on HEX5
//     Wrap             one-cycle pulse after Pos wraps L-1 -> 0
//
//   Build option: define HEX_SCROLL_BLINK_EN to blank all digits on
//   alternate Ticks while paused.
// ---------------------------------------------------------------------------
module hex_scroll_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          Tick,
  input  logic          Run,
  input  logic [AW:0]   Len,
  input  logic          Wr_en,
  input  logic [AW-1:0] Wr_addr,
  input  logic [2:0]    Wr_char,
  output logic [6:0]    HEX5,
  output logic [6:0]    HEX4,
  output logic [6:0]    HEX3,
  output logic [6:0]    HEX2,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX0,
  output logic [AW-1:0] Pos,
  output logic          Wrap
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW-1:0] pos_r;
  logic          wrap_r;
  logic [2:0]    buf_r [DEPTH];
  logic [6:0]    hex_r [6];       // hex_r[0] drives HEX5

  logic [AW:0]   len_s;
  logic          last_s;
  logic          pos_oor_s;
  logic          advance_s;
  logic          blank_s;
  logic [AW-1:0] idx_s [6];

  // Character code to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [2:0] code);
    case (code)
      3'd0:    seg_decode = 7'b0001001;  // H
      3'd1:    seg_decode = 7'b0000110;  // E
      3'd2:    seg_decode = 7'b1000111;  // L
      3'd3:    seg_decode = 7'b1000000;  // O
      3'd4:    seg_decode = 7'b0100001;  // d
      3'd5:    seg_decode = 7'b0001100;  // P
      3'd6:    seg_decode = 7'b0111111;  // -
      default: seg_decode = 7'b1111111;  // blank
    endcase
  endfunction

  // Reset contents of the buffer: "HELLO" then blanks.
  function automatic logic [2:0] preset_char(input logic [4:0] idx);
    case (idx)
      5'd0:    preset_char = 3'd0;
      5'd1:    preset_char = 3'd1;
      5'd2:    preset_char = 3'd2;
      5'd3:    preset_char = 3'd2;
      5'd4:    preset_char = 3'd3;
      default: preset_char = 3'd7;
    endcase
  endfunction

  // Clamp Len to 1..DEPTH and derive the advance/wrap conditions.
  always_comb begin
    if (Len == '0) begin
      len_s = (AW+1)'(1);
    end else if (Len > (AW+1)'(DEPTH)) begin
      len_s = (AW+1)'(DEPTH);
    end else begin
      len_s = Len;
    end
    last_s    = ({1'b0, pos_r} == (len_s - (AW+1)'(1)));
    pos_oor_s = ({1'b0, pos_r} >= len_s);
    advance_s = (state_r == SCROLL) && Run && Tick;
  end

  // Window addresses; the modulo lets short messages repeat across digits.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      idx_s[i] = AW'(({3'b000, pos_r} + (AW+3)'(i)) % (AW+3)'(len_s));
    end
  end

  // Control FSM with Pos and Wrap as registered outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      pos_r   <= '0;
      wrap_r  <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      // A shrunken Len snaps Pos home silently; this wins over any Tick.
      if (pos_oor_s) begin
        pos_r <= '0;
      end else if (advance_s) begin
        pos_r  <= last_s ? '0 : pos_r + AW'(1);
        wrap_r <= last_s;
      end else begin
        pos_r <= pos_r;
      end
      case (state_r)
        IDLE:    state_r <= Run ? SCROLL : IDLE;
        SCROLL:  state_r <= Run ? SCROLL : PAUSE;
        PAUSE:   state_r <= Run ? SCROLL : PAUSE;
        default: begin
          state_r <= IDLE;
          pos_r   <= '0;
        end
      endcase
    end
  end

`ifdef HEX_SCROLL_BLINK_EN
  logic blink_r;

  // Blink flag: toggles per Tick while staying paused, cleared otherwise.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      blink_r <= 1'b0;
    end else if ((state_r == PAUSE) && !Run) begin
      blink_r <= Tick ? ~blink_r : blink_r;
    end else begin
      blink_r <= 1'b0;
    end
  end

  assign blank_s = blink_r;
`else
  assign blank_s = 1'b0;
`endif

  // Character buffer, restored to the preset message on reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        buf_r[k] <= preset_char(5'(k));
      end
    end else if (Wr_en) begin
      buf_r[Wr_addr] <= Wr_char;
    end
  end

  // Registered segment outputs, one cycle behind Pos and the buffer.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= 7'h7F;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        hex_r[i] <= blank_s ? 7'h7F : seg_decode(buf_r[idx_s[i]]);
      end
    end
  end

  assign HEX5 = hex_r[0];
  assign HEX4 = hex_r[1];
  assign HEX3 = hex_r[2];
  assign HEX2 = hex_r[3];
  assign HEX1 = hex_r[4];
  assign HEX0 = hex_r[5];
  assign Pos  = pos_r;
  assign Wrap = wrap_r;

endmodule
